// File: rtl/instr_word_assembler.sv
// Fetch-stage assembler: collects a head word plus up to MAX_EXT extension words
// and presents one complete instruction per valid/ready transfer.
module instr_word_assembler #(
  parameter int WORD_W  = 16,
  parameter int LEN_LSB = 2,
  parameter int LEN_W   = 2,
  parameter int MAX_EXT = 2,
  parameter int PC_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [WORD_W-1:0]         word_in,
  input  logic [PC_W-1:0]           word_pc,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_instr,
  output logic [MAX_EXT*WORD_W-1:0] out_imm,
  output logic [LEN_W-1:0]          out_len,
  output logic [PC_W-1:0]           out_pc,
  output logic                      out_illegal
);

  localparam int IMM_W = MAX_EXT * WORD_W;
  localparam int IDX_W = (MAX_EXT > 1) ? $clog2(MAX_EXT) : 1;
  localparam logic [LEN_W:0] MAX_EXT_C = (LEN_W+1)'(MAX_EXT);
  localparam logic [LEN_W:0] CNT_ONE   = (LEN_W+1)'(1);

  localparam logic [0:0] S_HEAD = 1'b0;
  localparam logic [0:0] S_EXT  = 1'b1;

  logic [0:0]        state;
  logic [LEN_W:0]    ext_cnt;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] head_buf;
  logic [PC_W-1:0]   pc_buf;
  logic [IMM_W-1:0]  imm_buf;
  logic [LEN_W-1:0]  len_buf;
  logic              illegal_buf;

  logic              accept;
  logic [LEN_W-1:0]  len_field;
  logic              head_illegal;
  logic [LEN_W-1:0]  head_eff_len;
  logic [IMM_W-1:0]  imm_next;

  assign word_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept     = word_valid && word_ready;

  always_comb begin
    len_field    = word_in[LEN_LSB +: LEN_W];
    head_illegal = ({1'b0, len_field} > MAX_EXT_C);
    head_eff_len = head_illegal ? MAX_EXT_C[LEN_W-1:0] : len_field;
  end

  // Buffer with the current word merged into slot idx, so completion can load
  // out_imm in the same edge as the last extension word is captured.
  always_comb begin
    imm_next = imm_buf;
    for (int unsigned i = 0; i < MAX_EXT; i++) begin
      if (idx == IDX_W'(i)) imm_next[i*WORD_W +: WORD_W] = word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HEAD;
      ext_cnt     <= '0;
      idx         <= '0;
      head_buf    <= '0;
      pc_buf      <= '0;
      imm_buf     <= '0;
      len_buf     <= '0;
      illegal_buf <= 1'b0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_imm     <= '0;
      out_len     <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= S_HEAD;
      ext_cnt   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (state == S_HEAD) begin
          head_buf    <= word_in;
          pc_buf      <= word_pc;
          imm_buf     <= '0;
          len_buf     <= head_eff_len;
          illegal_buf <= head_illegal;
          idx         <= '0;
          if (head_eff_len == '0) begin
            ext_cnt     <= '0;
            out_valid   <= 1'b1;
            out_instr   <= word_in;
            out_imm     <= '0;
            out_len     <= '0;
            out_pc      <= word_pc;
            out_illegal <= head_illegal;
          end else begin
            ext_cnt <= {1'b0, head_eff_len};
            state   <= S_EXT;
          end
        end else begin
          imm_buf <= imm_next;
          ext_cnt <= ext_cnt - CNT_ONE;
          idx     <= idx + IDX_W'(1);
          if (ext_cnt == CNT_ONE) begin
            idx         <= '0;
            state       <= S_HEAD;
            out_valid   <= 1'b1;
            out_instr   <= head_buf;
            out_imm     <= imm_next;
            out_len     <= len_buf;
            out_pc      <= pc_buf;
            out_illegal <= illegal_buf;
          end
        end
      end
    end
  end

endmodule

// File: doc/instr_word_assembler.md
Name: instr_word_assembler

Overview:
- Fetch-stage block between instruction memory and the IF/ID register.
- Assembles variable-length instructions from a stream of WORD_W-bit fetch words. The head word carries a length field giving the number of extension (immediate) words that follow.
- Presents one complete instruction per valid/ready transfer: head word, packed immediate, length and fetch PC.
- Supports downstream stall, pipeline flush and an illegal-length flag, generalising the single-flag 16/32-bit detection to N extension words.

Parameters:
- WORD_W, 16, width of one fetch word and of the head instruction.
- LEN_LSB, 2, bit position of the length field LSB inside the head word.
- LEN_W, 2, width of the length field.
- MAX_EXT, 2, maximum legal extension words; out_imm is MAX_EXT*WORD_W bits.
- PC_W, 32, width of the fetch PC.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous abort of any partial or held instruction (branch/exception redirect).
- word_in, input, WORD_W, fetch word from instruction memory.
- word_pc, input, PC_W, address of word_in.
- word_valid, input, 1, word_in/word_pc are valid this cycle.
- word_ready, output, 1, the assembler accepts word_in this cycle.
- out_valid, output, 1, out_* hold a complete instruction.
- out_ready, input, 1, the decode stage accepts the instruction this cycle.
- out_instr, output, WORD_W, head word.
- out_imm, output, MAX_EXT*WORD_W, packed extension words.
- out_len, output, LEN_W, number of extension words actually collected.
- out_pc, output, PC_W, PC of the head word.
- out_illegal, output, 1, the head length field exceeded MAX_EXT.

Behaviour:
- Accept = word_valid && word_ready. Transfer out = out_valid && out_ready.
- word_ready = !rst && !flush && (!out_valid || out_ready). This is combinational, with no bubble when the consumer is ready.
- States: S_HEAD (expecting head word) and S_EXT (collecting extension words). Counter ext_cnt is LEN_W+1 bits; slot index idx runs 0..MAX_EXT-1.
- S_HEAD on accept:
  - Capture the head word, word_pc and len = word_in[LEN_LSB +: LEN_W].
  - Clear the immediate buffer to 0.
  - If len > MAX_EXT: set illegal = 1 and use eff_len = MAX_EXT; otherwise eff_len = len and illegal = 0.
  - If eff_len == 0: load out_* and set out_valid = 1 at the next edge (1-cycle latency); out_imm = 0, out_len = 0; stay in S_HEAD.
  - Otherwise: ext_cnt = eff_len, idx = 0, go to S_EXT.
- S_EXT on accept:
  - imm_buf[idx*WORD_W +: WORD_W] = word_in. The first extension word goes in the least-significant slot.
  - idx += 1, ext_cnt -= 1.
  - When ext_cnt reaches 0 on this accept: load out_* (out_len = eff_len, out_illegal = illegal), set out_valid = 1 next edge, go to S_HEAD.
  - word_pc of extension words is ignored.
- Output register:
  - out_valid clears on transfer out, unless a new instruction completes in the same cycle; completion wins and reloads out_*.
  - out_* hold stable while out_valid && !out_ready.
- No accept when word_valid = 0: state and counters hold, and waiting is unbounded.
- Flush: next edge gives state = S_HEAD, out_valid = 0, ext_cnt = 0, idx = 0. The word presented in the flush cycle is not accepted (word_ready = 0). Partial immediates are discarded.
- Reset: rst has priority over flush. Next edge gives state = S_HEAD, out_valid = 0, out_instr = 0, out_imm = 0, out_len = 0, out_pc = 0, out_illegal = 0, ext_cnt = 0, idx = 0. word_ready = 0 while rst is high. A reset in S_EXT drops the partial instruction.
- Unused out_imm slots (index ≥ out_len) are 0.
- Degenerate configuration LEN_W = 1, MAX_EXT = 1: illegal can never be set.

Test Plan:
- Short instruction: word_in = 16'h1230 (bits[3:2] = 0), pc = 0x100, out_ready = 1 → next cycle out_valid = 1, out_instr = 16'h1230, out_imm = 0, out_len = 0, out_pc = 0x100; back-to-back 16'h0000 heads give one instruction per cycle.
- Two-word immediate: head 16'hA008 (len = 2) at pc 0x200, then 16'h1111, 16'h2222 → one cycle after the last word, out_imm = 32'h2222_1111, out_len = 2, out_pc = 0x200, out_illegal = 0.
- Stall: complete 16'h0004 + 16'hBEEF with out_ready = 0 for 3 cycles → out_* stable, word_ready = 0, no new words consumed; out_ready = 1 → transfer occurs, word_ready = 1 the same cycle.
- Illegal length: head 16'h000C (len = 3), then 16'h0001, 16'h0002, 16'h0003 → instruction completes after 2 extension words, out_len = 2, out_illegal = 1; 16'h0003 is treated as the next head.
- Flush mid-assembly: head 16'h0008, one extension word, then flush = 1 with word_valid = 1 → word not accepted, out_valid stays 0; next head 16'h0000 completes normally with out_imm = 0.
- Reset mid-operation: rst = 1 in S_EXT and while out_valid = 1 → all outputs 0 next edge, word_ready = 0 during reset; after release a fresh 16'h0004 + 16'h00FF sequence yields out_imm = 32'h0000_00FF.
